// File: rtl/bht_sat_counter_table.sv
// -----------------------------------------------------------------------------
// bht_sat_counter_table
//   Branch history table of 2-bit saturating counters. The table is indexed by
//   pc[INDEX_LSB +: IDX_W]. Higher PC bits alias onto the same entry, and bits
//   below INDEX_LSB are ignored. A lookup gives a registered taken/not-taken
//   prediction one cycle later. Resolved outcomes train the counters with a
//   single-cycle saturating read-modify-write. After reset or flush, the table
//   is cleared to weak-not-taken (01), one entry per cycle. Lookups and updates
//   are honoured only once that clear has finished.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   flush_i         restart the table clear
//   lookup_valid_i  lookup request this cycle
//   lookup_pc_i     PC to predict
//   pred_valid_o    prediction valid (one cycle after the lookup)
//   pred_taken_o    predicted direction (counter MSB), 0 when not valid
//   update_valid_i  resolved branch outcome this cycle
//   update_pc_i     PC of the resolved branch
//   update_taken_i  resolved direction
//   ready_o         clear finished; lookups and updates are honoured
// -----------------------------------------------------------------------------
module bht_sat_counter_table #(
  parameter int NR_ENTRIES = 1024,
  parameter int VLEN       = 32,
  parameter int INDEX_LSB  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  logic            update_valid_i,
  input  logic [VLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  output logic            ready_o
);

  localparam int IDX_W = $clog2(NR_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);
  localparam logic [1:0] CNT_CLEARED = 2'b01;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             ready_q;

  logic [1:0]       table_q [NR_ENTRIES];

  logic [IDX_W-1:0] lkp_idx_p0;
  logic [IDX_W-1:0] upd_idx_p0;
  logic             lkp_fire_p0;
  logic             upd_fire_p0;
  logic             vld_p1;
  logic             taken_p1;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_data;

  // Only the index bits of each PC matter. The reduction marks the rest as
  // deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i, update_pc_i};

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) res = (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else       res = (cnt == 2'b00) ? cnt : cnt - 2'd1;
    return res;
  endfunction

  assign lkp_idx_p0  = lookup_pc_i[INDEX_LSB +: IDX_W];
  assign upd_idx_p0  = update_pc_i[INDEX_LSB +: IDX_W];
  assign lkp_fire_p0 = (state_q == READY) && lookup_valid_i && !flush_i;
  assign upd_fire_p0 = (state_q == READY) && update_valid_i && !flush_i;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (flush_i) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
    end else if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LAST_IDX) state_d = READY;
    end
  end

  // The table has one write port. The clear and the training update never
  // compete for it, because they happen in different states.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = upd_idx_p0;
    wr_data = sat_update(table_q[upd_idx_p0], update_taken_i);
    if (!rst_i) begin
      if (state_q == CLEAR && !flush_i) begin
        wr_en   = 1'b1;
        wr_idx  = clr_idx_q;
        wr_data = CNT_CLEARED;
      end else if (upd_fire_p0) begin
        wr_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      vld_p1    <= 1'b0;
      taken_p1  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= (state_d == READY);
      vld_p1    <= lkp_fire_p0;
      taken_p1  <= lkp_fire_p0 & table_q[lkp_idx_p0][1];
    end
  end

  // ---- stage p0 -> p1: the array read above samples the pre-write value, so
  // a same-cycle lookup and update to one entry returns the old counter.
  always_ff @(posedge clk_i) begin
    if (wr_en) table_q[wr_idx] <= wr_data;
  end

  assign pred_valid_o = vld_p1;
  assign pred_taken_o = taken_p1;
  assign ready_o      = ready_q;

endmodule
